// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate decode (I/S/B/U/J/zimm) into STAGES elastic valid/ready register stages; latency STAGES edges.
// Backpressure: ready ripples combinationally from out_ready so a full pipe still moves 1 entry/cycle; flush clears every stage.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             imm_err
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  logic [31:0] imm32;
  logic        dec_err;
  entry_t      dec;

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32   = '0;
    dec_err = 1'b0;
    case (imm_src)
      3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011:  imm32 = {instr[31:12], 12'b0};
      3'b100:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      3'b101:  imm32 = {27'b0, instr[19:15]};
      default: dec_err = 1'b1;
    endcase
    // zimm has bit 31 clear, so one sign-extension serves every format.
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
    dec.tag       = in_tag;
    dec.err       = dec_err;
  end

  logic [STAGES-1:0] vld;
  entry_t            dat [STAGES];
  logic [STAGES:0]   gate;

  // gate[k]: stage k may load this edge (empty, or its contents move on).
  always_comb begin
    gate         = '0;
    gate[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      gate[k] = !vld[k] || gate[k+1];
    end
  end

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stg
    logic   vld_q, vld_d;
    entry_t dat_q, dat_d;
    logic   src_vld;
    entry_t src_dat;

    if (k == 0) begin : g_src
      assign src_vld = in_valid;
      assign src_dat = dec;
    end else begin : g_src
      assign src_vld = vld[k-1];
      assign src_dat = dat[k-1];
    end

    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (flush) begin
        vld_d = 1'b0;
      end else if (gate[k]) begin
        vld_d = src_vld;
      end
      if (gate[k] && src_vld) begin
        dat_d = src_dat;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign vld[k] = vld_q;
    assign dat[k] = dat_q;
  end

  assign in_ready  = gate[0];
  assign out_valid = vld[STAGES-1];
  assign imm_ext   = dat[STAGES-1].imm;
  assign out_tag   = dat[STAGES-1].tag;
  assign imm_err   = dat[STAGES-1].err;

endmodule
